card_datapath: RTL and testbench
================================

CARD_DATAPATH -- requirements
Module: card_datapath

Interface
REQ-001 The module SHALL have the port slow_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the slow_clock rising edge.
REQ-003 The module SHALL have the ports load_pcard1, load_pcard2, load_pcard3, input, 1 bit each: player slot capture strobes from the dealing state machine.
REQ-004 The module SHALL have the ports load_dcard1, load_dcard2, load_dcard3, input, 1 bit each: dealer slot capture strobes.
REQ-005 The module SHALL have the ports pcard1, pcard2, pcard3, output, 4 bits each: registered player cards; 0 = empty, 1 = A, 2-10, 11 = J, 12 = Q, 13 = K.
REQ-006 The module SHALL have the ports dcard1, dcard2, dcard3, output, 4 bits each: registered dealer cards, same encoding.
REQ-007 The module SHALL have the ports pscore and dscore, output, 4 bits each: hand scores 0-9.
REQ-008 The module SHALL have the port cards_dealt, output, 3 bits: number of slots loaded since reset, 0-6.
REQ-009 The module SHALL have the port load_error, output, 1 bit: sticky flag for illegal load activity.

Function
REQ-010 The module SHALL contain a card source counter, 4 bits, reset value 1, that advances by 1 on every non-reset clock and wraps 13 -> 1; it never holds 0 or 14-15.
REQ-011 On a clock edge with exactly one load strobe high and the target slot empty (0), that slot SHALL capture the card source counter value present before the edge.
REQ-012 A captured card SHALL be visible on its output in the cycle after the strobe (1-cycle latency) and SHALL hold until reset.
REQ-013 A strobe to an already loaded slot SHALL leave the slot unchanged, leave cards_dealt unchanged, and set load_error.
REQ-014 Two or more strobes high on the same edge SHALL load nothing, leave cards_dealt unchanged, and set load_error.
REQ-015 Card point value SHALL be: 0 for empty and for 10-13; the face value for 1-9.
REQ-016 pscore SHALL equal (value(pcard1) + value(pcard2) + value(pcard3)) mod 10, and dscore likewise for the dealer cards, both computed combinationally from the slot registers with no added latency; the intermediate sum width SHALL be at least 5 bits (max 27).
REQ-017 cards_dealt SHALL increment by 1 on each successful load and saturate at 6.
REQ-018 Once set, load_error SHALL stay 1 until reset.
REQ-019 The card source counter SHALL advance in every non-reset cycle, regardless of whether a load occurs.

Reset
REQ-020 While reset is high at an edge, the module SHALL clear all six slots to 0 and set the card source counter to 1, cards_dealt to 0 and load_error to 0; pscore and dscore therefore read 0.
REQ-021 Reset SHALL override any load strobe on the same edge, including a reset asserted mid-deal.
REQ-022 On the first edge after reset deasserts, the card source counter SHALL still read 1 before that edge, so a strobe on that edge captures 1 (ace).

Verification
REQ-023 The bench SHALL drive reset for one edge, then load_pcard1 on the next edge -> pcard1=1, pscore=1, cards_dealt=1.
REQ-024 The bench SHALL run the counter without strobes for 13 edges after reset -> counter sequence 1..13 then back to 1; the next strobe captures 1.
REQ-025 The bench SHALL load player cards 7 and 8 -> pscore=5; then load a K (13) into pcard3 -> pscore stays 5.
REQ-026 The bench SHALL load 9, 9, 9 into the dealer slots -> dscore=7 (27 mod 10) and cards_dealt=3.
REQ-027 The bench SHALL strobe load_pcard2 twice, then strobe load_dcard1 and load_dcard2 together -> pcard2 holds its first value, the dealer slots stay 0, load_error=1 from the second strobe onward, and cards_dealt=1.
REQ-028 The bench SHALL assert reset after 4 loads while load_dcard3 is high -> all slots 0, scores 0, cards_dealt=0, load_error=0, and dcard3 not loaded.

Source files
------------

// File: rtl/card_datapath.sv
// ----------------------------------------------------------------------------
// card_datapath
//
// Card-slot datapath for a baccarat-style dealer. A free-running card source
// counter cycles through 1..13 (A..K). When the dealing state machine pulses
// one slot strobe, that slot captures the counter's value. Each slot captures
// only once until reset. Hand scores are the sum of the card point values,
// taken mod 10.
//
// Ports
//   slow_clock                    : clock; all state updates on its rising edge
//   reset                         : synchronous, active-high reset
//   load_pcard1..3                : player slot capture strobes
//   load_dcard1..3                : dealer slot capture strobes
//   pcard1..3, dcard1..3  [3:0]   : registered cards (0 = empty, 1..13 = A..K)
//   pscore, dscore        [3:0]   : hand scores 0..9 (combinational from slots)
//   cards_dealt           [2:0]   : successful loads since reset, saturates at 6
//   load_error                    : sticky flag for an illegal strobe pattern
// ----------------------------------------------------------------------------
module card_datapath (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       load_error
);

    // Slot index order: 0..2 = player cards 1..3, 3..5 = dealer cards 1..3.
    logic [5:0][3:0] slot_q, slot_d;
    logic [3:0]      src_q, src_d;
    logic [2:0]      dealt_q, dealt_d;
    logic            err_q, err_d;

    logic [5:0] strobe;
    logic [5:0] strobe_m1;
    logic       multi_strobe;
    logic       single_strobe;

    assign strobe = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

    // Clearing the lowest set bit leaves something only if two or more bits
    // were set.
    assign strobe_m1     = strobe - 6'd1;
    assign multi_strobe  = (strobe & strobe_m1) != 6'd0;
    assign single_strobe = (strobe != 6'd0) && !multi_strobe;

    always_comb begin
        src_d   = (src_q == 4'd13) ? 4'd1 : src_q + 4'd1;
        slot_d  = slot_q;
        dealt_d = dealt_q;
        err_d   = err_q;
        if (multi_strobe) begin
            err_d = 1'b1;
        end else if (single_strobe) begin
            for (int i = 0; i < 6; i++) begin
                if (strobe[i]) begin
                    if (slot_q[i] == 4'd0) begin
                        // Capture the value the counter held before this edge.
                        slot_d[i] = src_q;
                        if (dealt_q != 3'd6) begin
                            dealt_d = dealt_q + 3'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            slot_q  <= '0;
            src_q   <= 4'd1;
            dealt_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            src_q   <= src_d;
            dealt_q <= dealt_d;
            err_q   <= err_d;
        end
    end

    // Point value: ten and the face cards count as zero, as does an empty slot.
    function automatic logic [4:0] card_value(input logic [3:0] card);
        return (card <= 4'd9) ? {1'b0, card} : 5'd0;
    endfunction

    logic [4:0] psum;
    logic [4:0] dsum;
    logic [4:0] pmod;
    logic [4:0] dmod;

    // Worst case 9+9+9 = 27 fits in 5 bits.
    assign psum = card_value(slot_q[0]) + card_value(slot_q[1]) + card_value(slot_q[2]);
    assign dsum = card_value(slot_q[3]) + card_value(slot_q[4]) + card_value(slot_q[5]);
    assign pmod = psum % 5'd10;
    assign dmod = dsum % 5'd10;

    assign pcard1      = slot_q[0];
    assign pcard2      = slot_q[1];
    assign pcard3      = slot_q[2];
    assign dcard1      = slot_q[3];
    assign dcard2      = slot_q[4];
    assign dcard3      = slot_q[5];
    assign pscore      = pmod[3:0];
    assign dscore      = dmod[3:0];
    assign cards_dealt = dealt_q;
    assign load_error  = err_q;

endmodule

// File: tb/tb_card_datapath.sv
// ----------------------------------------------------------------------------
// tb_card_datapath
//
// Directed bench for card_datapath. A table of {reset, strobes, idle edges
// before the step, expected outputs} records is applied in a loop. Hand-written
// sequences then cover the counter wrap and a long reset held with strobes high.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_card_datapath;

    // Strobe bit positions: {d3, d2, d1, p3, p2, p1}
    localparam logic [5:0] P1 = 6'b000001;
    localparam logic [5:0] P2 = 6'b000010;
    localparam logic [5:0] P3 = 6'b000100;
    localparam logic [5:0] D1 = 6'b001000;
    localparam logic [5:0] D2 = 6'b010000;
    localparam logic [5:0] D3 = 6'b100000;

    logic       slow_clock;
    logic       reset;
    logic [5:0] ld;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic [2:0] cards_dealt;
    logic       load_error;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- clock / reset ----------------
    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    card_datapath dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .load_pcard1 (ld[0]),
        .load_pcard2 (ld[1]),
        .load_pcard3 (ld[2]),
        .load_dcard1 (ld[3]),
        .load_dcard2 (ld[4]),
        .load_dcard3 (ld[5]),
        .pcard1      (pcard1),
        .pcard2      (pcard2),
        .pcard3      (pcard3),
        .dcard1      (dcard1),
        .dcard2      (dcard2),
        .dcard3      (dcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .cards_dealt (cards_dealt),
        .load_error  (load_error)
    );

    // ---------------- vector table ----------------
    typedef struct {
        int         idle;
        logic       rst;
        logic [5:0] ld;
        logic [3:0] p1, p2, p3, d1, d2, d3;
        logic [3:0] ps, ds;
        logic [2:0] cd;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int idle, logic rst, logic [5:0] l,
                                logic [3:0] p1, logic [3:0] p2, logic [3:0] p3,
                                logic [3:0] d1, logic [3:0] d2, logic [3:0] d3,
                                logic [3:0] ps, logic [3:0] ds, logic [2:0] cd,
                                logic err);
        vec_t v;
        v.idle = idle; v.rst = rst; v.ld = l;
        v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.ps = ps; v.ds = ds; v.cd = cd; v.err = err;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst, input logic [5:0] l);
        @(negedge slow_clock);
        reset = rst;
        ld    = l;
        @(posedge slow_clock);
        #1;
    endtask

    task automatic idle_edges(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".pcard1"}, int'(pcard1), int'(v.p1));
        check({tag, ".pcard2"}, int'(pcard2), int'(v.p2));
        check({tag, ".pcard3"}, int'(pcard3), int'(v.p3));
        check({tag, ".dcard1"}, int'(dcard1), int'(v.d1));
        check({tag, ".dcard2"}, int'(dcard2), int'(v.d2));
        check({tag, ".dcard3"}, int'(dcard3), int'(v.d3));
        check({tag, ".pscore"}, int'(pscore), int'(v.ps));
        check({tag, ".dscore"}, int'(dscore), int'(v.ds));
        check({tag, ".cards_dealt"}, int'(cards_dealt), int'(v.cd));
        check({tag, ".load_error"}, int'(load_error), int'(v.err));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t zero;
        reset = 1'b1;
        ld    = 6'd0;
        zero  = mk(0, 1'b1, 6'd0, 0,0,0, 0,0,0, 0,0, 0, 1'b0);

        // First ace after reset.
        vecs.push_back(zero);
        vecs.push_back(mk(0, 1'b0, P1, 1,0,0, 0,0,0, 1,0, 1, 1'b0));

        // 7 + 8 -> 5, then a king leaves the score at 5.
        vecs.push_back(zero);
        vecs.push_back(mk(6, 1'b0, P1, 7,0,0,  0,0,0, 7,0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b0, P2, 7,8,0,  0,0,0, 5,0, 2, 1'b0));
        vecs.push_back(mk(4, 1'b0, P3, 7,8,13, 0,0,0, 5,0, 3, 1'b0));

        // Three nines for the dealer: 27 mod 10 = 7. Nines recur every 13 edges.
        vecs.push_back(zero);
        vecs.push_back(mk(8,  1'b0, D1, 0,0,0, 9,0,0, 0,9, 1, 1'b0));
        vecs.push_back(mk(12, 1'b0, D2, 0,0,0, 9,9,0, 0,8, 2, 1'b0));
        vecs.push_back(mk(12, 1'b0, D3, 0,0,0, 9,9,9, 0,7, 3, 1'b0));

        // Reload of a full slot, then a double strobe: errors, nothing loaded.
        vecs.push_back(zero);
        vecs.push_back(mk(0, 1'b0, P2,      0,1,0, 0,0,0, 1,0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b0, P2,      0,1,0, 0,0,0, 1,0, 1, 1'b1));
        vecs.push_back(mk(0, 1'b0, D1 | D2, 0,1,0, 0,0,0, 1,0, 1, 1'b1));
        vecs.push_back(mk(3, 1'b0, 6'd0,    0,1,0, 0,0,0, 1,0, 1, 1'b1));

        // Reset mid-deal overrides a dcard3 strobe. The next strobe takes an ace.
        vecs.push_back(zero);
        vecs.push_back(mk(0, 1'b0, P1, 1,0,0, 0,0,0, 1,0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b0, P2, 1,2,0, 0,0,0, 3,0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b0, D1, 1,2,0, 3,0,0, 3,3, 3, 1'b0));
        vecs.push_back(mk(0, 1'b0, D2, 1,2,0, 3,4,0, 3,7, 4, 1'b0));
        vecs.push_back(mk(0, 1'b1, D3, 0,0,0, 0,0,0, 0,0, 0, 1'b0));
        vecs.push_back(mk(0, 1'b0, D3, 0,0,0, 0,0,1, 0,1, 1, 1'b0));

        // Fill all six slots, then strobe again: the count stays at 6.
        vecs.push_back(zero);
        vecs.push_back(mk(0, 1'b0, P1, 1,0,0, 0,0,0, 1,0, 1, 1'b0));
        vecs.push_back(mk(0, 1'b0, P2, 1,2,0, 0,0,0, 3,0, 2, 1'b0));
        vecs.push_back(mk(0, 1'b0, P3, 1,2,3, 0,0,0, 6,0, 3, 1'b0));
        vecs.push_back(mk(0, 1'b0, D1, 1,2,3, 4,0,0, 6,4, 4, 1'b0));
        vecs.push_back(mk(0, 1'b0, D2, 1,2,3, 4,5,0, 6,9, 5, 1'b0));
        vecs.push_back(mk(0, 1'b0, D3, 1,2,3, 4,5,6, 6,5, 6, 1'b0));
        vecs.push_back(mk(0, 1'b0, P1, 1,2,3, 4,5,6, 6,5, 6, 1'b1));

        foreach (vecs[i]) begin
            idle_edges(vecs[i].idle);
            step(vecs[i].rst, vecs[i].ld);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Counter sweep: after k-1 idle edges the strobe takes card k. It wraps 13 -> 1.
        for (int k = 1; k <= 14; k++) begin
            int exp_card;
            int exp_score;
            exp_card  = ((k - 1) % 13) + 1;
            exp_score = (exp_card <= 9) ? exp_card : 0;
            step(1'b1, 6'd0);
            idle_edges(k - 1);
            step(1'b0, D1);
            check($sformatf("sweep%0d.dcard1", k), int'(dcard1), exp_card);
            check($sformatf("sweep%0d.dscore", k), int'(dscore), exp_score);
            check($sformatf("sweep%0d.cards_dealt", k), int'(cards_dealt), 1);
        end

        // Reset held for three edges with every strobe high: nothing loads.
        step(1'b0, P1);
        step(1'b1, 6'h3f);
        step(1'b1, 6'h3f);
        step(1'b1, 6'h3f);
        check("hold.pcard1", int'(pcard1), 0);
        check("hold.cards_dealt", int'(cards_dealt), 0);
        check("hold.load_error", int'(load_error), 0);
        step(1'b0, P3);
        check("hold.pcard3_after", int'(pcard3), 1);
        check("hold.pscore_after", int'(pscore), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
